// File: rtl/request_unit.sv
// Request sequencer between the single-cycle datapath and memory control.
// Issues fetch and data requests, gates the PC, tracks halt and retirement.
module request_unit #(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             ctl_dREN,
   input  logic             ctl_dWEN,
   input  logic             ctl_halt,
   output logic             iREN,
   output logic             dREN,
   output logic             dWEN,
   output logic             pc_en,
   output logic             halt,
   output logic             timeout,
   output logic [CNT_W-1:0] instr_cnt
);

   localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WW-1:0] TMAX = WW'(TIMEOUT);

   typedef enum logic [1:0] {
      IFETCH,
      DACCESS,
      HALTED
   } state_t;

   state_t        state;
   logic [WW-1:0] wcnt;

   logic in_if;
   logic in_da;
   logic if_hit;
   logic da_hit;
   logic go_halt;
   logic go_dacc;
   logic waiting;

   assign in_if   = (state == IFETCH);
   assign in_da   = (state == DACCESS);
   assign if_hit  = in_if & ihit;
   assign da_hit  = in_da & dhit;
   assign go_halt = if_hit & ctl_halt;
   assign go_dacc = if_hit & ~ctl_halt & (ctl_dREN | ctl_dWEN);

   assign pc_en = (if_hit & ~ctl_halt & ~ctl_dREN & ~ctl_dWEN)
                | da_hit;

   // only the hit that matches the current state counts as progress
   assign waiting = (in_if & ~ihit) | (in_da & ~dhit);

   assign iREN = in_if;
   assign halt = (state == HALTED);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state     <= IFETCH;
         dREN      <= 1'b0;
         dWEN      <= 1'b0;
         timeout   <= 1'b0;
         instr_cnt <= '0;
         wcnt      <= '0;
      end else begin
         if (pc_en | go_halt)
            instr_cnt <= instr_cnt + CNT_W'(1);

         unique case (1'b1)
            go_halt: begin
               state <= HALTED;
               dREN  <= 1'b0;
               dWEN  <= 1'b0;
            end
            go_dacc: begin
               state <= DACCESS;
               dWEN  <= ctl_dWEN;
               dREN  <= ~ctl_dWEN;
            end
            da_hit: begin
               state <= IFETCH;
               dREN  <= 1'b0;
               dWEN  <= 1'b0;
            end
            default: ;
         endcase

         if (go_halt | go_dacc | pc_en) begin
            wcnt <= '0;
         end else if (waiting && wcnt != TMAX) begin
            wcnt <= wcnt + WW'(1);
            if (wcnt == TMAX - WW'(1))
               timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_request_unit.sv
// Self-checking bench for request_unit: one instance with a short
// watchdog and wide counter, one with watchdog off and a 4-bit counter.
module tb_request_unit;

   logic CLK = 1'b0;
   logic nRST;
   logic ihit, dhit, ctl_dREN, ctl_dWEN, ctl_halt;

   logic a_iREN, a_dREN, a_dWEN, a_pc_en, a_halt, a_timeout;
   logic [31:0] a_cnt;
   logic b_iREN, b_dREN, b_dWEN, b_pc_en, b_halt, b_timeout;
   logic [3:0] b_cnt;

   request_unit #(.TIMEOUT(4), .CNT_W(32)) u_a (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
      .ctl_dREN(ctl_dREN), .ctl_dWEN(ctl_dWEN), .ctl_halt(ctl_halt),
      .iREN(a_iREN), .dREN(a_dREN), .dWEN(a_dWEN), .pc_en(a_pc_en),
      .halt(a_halt), .timeout(a_timeout), .instr_cnt(a_cnt)
   );

   request_unit #(.TIMEOUT(0), .CNT_W(4)) u_b (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
      .ctl_dREN(ctl_dREN), .ctl_dWEN(ctl_dWEN), .ctl_halt(ctl_halt),
      .iREN(b_iREN), .dREN(b_dREN), .dWEN(b_dWEN), .pc_en(b_pc_en),
      .halt(b_halt), .timeout(b_timeout), .instr_cnt(b_cnt)
   );

   always #5 CLK = ~CLK;

   int n_chk = 0;
   int n_fail = 0;
   int unsigned exp_q[$];
   int unsigned mcnt;
   int unsigned e;

   task automatic drive(input logic ih, input logic dh,
                        input logic rd, input logic wr,
                        input logic hl);
      @(negedge CLK);
      ihit = ih; dhit = dh;
      ctl_dREN = rd; ctl_dWEN = wr; ctl_halt = hl;
      #1;
   endtask

   task automatic do_reset();
      @(negedge CLK);
      ihit = 0; dhit = 0; ctl_dREN = 0; ctl_dWEN = 0; ctl_halt = 0;
      nRST = 1'b0;
      @(negedge CLK);
      nRST = 1'b1;
      #1;
      mcnt = 0;
   endtask

   task automatic test_reset();
      do_reset();
      n_chk++;
      if ({a_iREN, a_dREN, a_dWEN, a_halt, a_timeout, a_pc_en} !== 6'b100000) begin
         n_fail++;
         $display("FAIL reset_flags: got %b expected 100000",
                  {a_iREN, a_dREN, a_dWEN, a_halt, a_timeout, a_pc_en});
      end
      n_chk++;
      if (a_cnt !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_cnt: got %0d expected 0", a_cnt);
      end
   endtask

   task automatic test_fetch();
      for (int i = 0; i < 6; i++) begin
         drive(i < 5, 0, 0, 0, 0);
         if (i > 0) begin
            e = exp_q.pop_front();
            n_chk++;
            if (a_cnt !== e) begin
               n_fail++;
               $display("FAIL fetch_cnt: got %0d expected %0d", a_cnt, e);
            end
         end
         if (i < 5) begin
            n_chk++;
            if (a_pc_en !== 1'b1 || a_iREN !== 1'b1) begin
               n_fail++;
               $display("FAIL fetch_pc_en: got pc_en=%b iREN=%b expected 1 1",
                        a_pc_en, a_iREN);
            end
            mcnt++;
            exp_q.push_back(mcnt);
         end
      end
      n_chk++;
      if (a_cnt !== 32'd5 || a_dREN !== 1'b0 || a_dWEN !== 1'b0) begin
         n_fail++;
         $display("FAIL fetch_final: got cnt=%0d dREN=%b dWEN=%b expected 5 0 0",
                  a_cnt, a_dREN, a_dWEN);
      end
   endtask

   task automatic test_load();
      drive(1, 0, 1, 0, 0);
      n_chk++;
      if (a_pc_en !== 1'b0) begin
         n_fail++;
         $display("FAIL load_issue_pc_en: got %b expected 0", a_pc_en);
      end
      for (int i = 0; i < 3; i++) begin
         drive(i == 1, 0, 0, 0, 0);
         n_chk++;
         if ({a_iREN, a_dREN, a_dWEN, a_pc_en} !== 4'b0100) begin
            n_fail++;
            $display("FAIL load_hold: got %b expected 0100",
                     {a_iREN, a_dREN, a_dWEN, a_pc_en});
         end
      end
      drive(0, 1, 0, 0, 0);
      n_chk++;
      if (a_pc_en !== 1'b1) begin
         n_fail++;
         $display("FAIL load_dhit_pc_en: got %b expected 1", a_pc_en);
      end
      mcnt++;
      exp_q.push_back(mcnt);
      drive(0, 0, 0, 0, 0);
      e = exp_q.pop_front();
      n_chk++;
      if (a_iREN !== 1'b1 || a_dREN !== 1'b0 || a_cnt !== e) begin
         n_fail++;
         $display("FAIL load_done: got iREN=%b dREN=%b cnt=%0d expected 1 0 %0d",
                  a_iREN, a_dREN, a_cnt, e);
      end
   endtask

   task automatic test_both();
      drive(1, 0, 1, 1, 0);
      drive(0, 0, 0, 0, 0);
      n_chk++;
      if (a_dWEN !== 1'b1 || a_dREN !== 1'b0 || a_iREN !== 1'b0) begin
         n_fail++;
         $display("FAIL both_store_wins: got dWEN=%b dREN=%b iREN=%b expected 1 0 0",
                  a_dWEN, a_dREN, a_iREN);
      end
      drive(1, 1, 0, 0, 0);
      n_chk++;
      if (a_pc_en !== 1'b1) begin
         n_fail++;
         $display("FAIL both_dhit_pc_en: got %b expected 1", a_pc_en);
      end
      mcnt++;
      drive(0, 1, 0, 0, 0);
      n_chk++;
      if (a_iREN !== 1'b1 || a_dWEN !== 1'b0 || a_pc_en !== 1'b0) begin
         n_fail++;
         $display("FAIL both_return: got iREN=%b dWEN=%b pc_en=%b expected 1 0 0",
                  a_iREN, a_dWEN, a_pc_en);
      end
      drive(0, 0, 0, 0, 0);
      n_chk++;
      if (a_cnt !== mcnt || b_cnt !== mcnt[3:0]) begin
         n_fail++;
         $display("FAIL both_cnt: got a=%0d b=%0d expected %0d %0d",
                  a_cnt, b_cnt, mcnt, mcnt[3:0]);
      end
   endtask

   task automatic test_watchdog();
      drive(1, 0, 0, 0, 0);
      mcnt++;
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 0, 0, 0);
         n_chk++;
         if (a_timeout !== (i == 4)) begin
            n_fail++;
            $display("FAIL wd_cycle%0d: got %b expected %b",
                     i, a_timeout, (i == 4));
         end
      end
      drive(1, 0, 0, 0, 0);
      mcnt++;
      n_chk++;
      if (a_pc_en !== 1'b1 || a_timeout !== 1'b1) begin
         n_fail++;
         $display("FAIL wd_resume: got pc_en=%b timeout=%b expected 1 1",
                  a_pc_en, a_timeout);
      end
      for (int i = 0; i < 100; i++) drive(0, 0, 0, 0, 0);
      n_chk++;
      if (a_timeout !== 1'b1 || b_timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL wd_sticky_disabled: got a=%b b=%b expected 1 0",
                  a_timeout, b_timeout);
      end
   endtask

   task automatic test_halt();
      drive(1, 0, 0, 1, 1);
      n_chk++;
      if (a_pc_en !== 1'b0) begin
         n_fail++;
         $display("FAIL halt_issue_pc_en: got %b expected 0", a_pc_en);
      end
      mcnt++;
      for (int i = 0; i < 5; i++) begin
         drive(1, i[0], i[1], 0, 0);
         n_chk++;
         if ({a_halt, a_iREN, a_dREN, a_dWEN, a_pc_en} !== 5'b10000
             || a_cnt !== mcnt) begin
            n_fail++;
            $display("FAIL halt_hold%0d: got %b cnt=%0d expected 10000 cnt=%0d",
                     i, {a_halt, a_iREN, a_dREN, a_dWEN, a_pc_en}, a_cnt, mcnt);
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      drive(1, 0, 0, 1, 0);
      drive(0, 0, 0, 0, 0);
      n_chk++;
      if (a_dWEN !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_store_up: got %b expected 1", a_dWEN);
      end
      #1 nRST = 1'b0;
      #1;
      n_chk++;
      if (a_dWEN !== 1'b0 || a_pc_en !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_async_drop: got dWEN=%b pc_en=%b expected 0 0",
                  a_dWEN, a_pc_en);
      end
      @(negedge CLK);
      nRST = 1'b1;
      #1;
      mcnt = 0;
      n_chk++;
      if (a_iREN !== 1'b1 || a_cnt !== 32'd0 || a_timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_release: got iREN=%b cnt=%0d timeout=%b expected 1 0 0",
                  a_iREN, a_cnt, a_timeout);
      end
   endtask

   task automatic test_wrap();
      logic [3:0] eb;
      for (int i = 0; i < 17; i++) begin
         drive(i < 16, 0, 0, 0, 0);
         if (i > 0) begin
            e = exp_q.pop_front();
            eb = e[3:0];
            n_chk++;
            if (b_cnt !== eb) begin
               n_fail++;
               $display("FAIL wrap_b%0d: got %0d expected %0d", i, b_cnt, eb);
            end
         end
         if (i < 16) begin
            mcnt++;
            exp_q.push_back(mcnt);
         end
      end
      n_chk++;
      if (a_cnt !== 32'd16 || b_cnt !== 4'd0) begin
         n_fail++;
         $display("FAIL wrap_final: got a=%0d b=%0d expected 16 0", a_cnt, b_cnt);
      end
   endtask

   initial begin
      nRST = 1'b0;
      ihit = 0; dhit = 0; ctl_dREN = 0; ctl_dWEN = 0; ctl_halt = 0;
      mcnt = 0;
      test_reset();
      test_fetch();
      test_load();
      test_both();
      test_watchdog();
      test_halt();
      test_reset_mid();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog_time: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

// File: doc/request_unit.md
Name: request_unit

Overview:
- Sequencer between the single-cycle datapath and the memory control for instruction and data requests.
- Consumes the datapath's decoded memory intent and the memory hit handshakes.
- Generates the instruction-read request, the data read/write requests, and the enable that lets the program counter advance.
- Also latches halt, counts retired instructions, and flags stalled memory transactions.

Parameters:
TIMEOUT, 64, cycles waiting for a hit before timeout asserts; 0 disables the watchdog
CNT_W, 32, width of the retired-instruction counter

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  asynchronous active-low reset
ihit  input  1  instruction memory hit, one cycle pulse or level
dhit  input  1  data memory hit
ctl_dREN  input  1  decoded instruction is a load
ctl_dWEN  input  1  decoded instruction is a store
ctl_halt  input  1  decoded instruction is HALT
iREN  output  1  instruction read request
dREN  output  1  data read request
dWEN  output  1  data write request
pc_en  output  1  program counter load enable
halt  output  1  sticky halted flag
timeout  output  1  sticky watchdog flag
instr_cnt  output  CNT_W  retired-instruction count

Behaviour:
- Reset (async, nRST=0):
  - state=IFETCH, dREN=0, dWEN=0, halt=0, timeout=0, instr_cnt=0, wait counter=0.
  - iREN=1 immediately after reset deasserts.
- States: IFETCH, DACCESS, HALTED.
  - iREN=1 only in IFETCH.
  - dREN/dWEN are registered and nonzero only in DACCESS.
  - halt=1 exactly when state=HALTED.
- pc_en is combinational, zero latency:
  - pc_en = (IFETCH & ihit & ~ctl_halt & ~ctl_dREN & ~ctl_dWEN) | (DACCESS & dhit).
  - pc_en is never 1 in HALTED.
- IFETCH on ihit, priority order:
  1. ctl_halt -> HALTED next cycle; memory intents ignored.
  2. ctl_dWEN -> DACCESS, dWEN<=1, dREN<=0. Store wins if both intents are set.
  3. ctl_dREN -> DACCESS, dREN<=1.
  4. Otherwise stay in IFETCH; pc_en pulses.
- IFETCH without ihit: stay; dhit is ignored.
- DACCESS on dhit: pc_en=1 that cycle; dREN/dWEN cleared next cycle; return to IFETCH. ihit is ignored in DACCESS.
- DACCESS without dhit: hold dREN/dWEN steady. The request must not drop or change until dhit.
- HALTED: absorbing until reset. All requests 0, pc_en=0, ihit/dhit ignored.
- instr_cnt:
  - Increments by 1 on every cycle with pc_en=1.
  - Also increments once on the entry cycle to HALTED (HALT counts as retired).
  - Wraps modulo 2^CNT_W.
- Wait counter:
  - Clears on every state transition and on each pc_en.
  - Increments each cycle spent in IFETCH or DACCESS with no qualifying hit; saturates at TIMEOUT.
  - When it reaches TIMEOUT (TIMEOUT>0), timeout<=1, sticky until reset.
  - Timeout does not change state; the block keeps waiting.
- Reset mid-transaction: outstanding dREN/dWEN drop asynchronously; state returns to IFETCH; no pc_en is generated.
- Simultaneous ihit and dhit: only the hit matching the current state is acted on.

Test Plan:
1. Reset, then ihit every cycle with no ctl intents for 5 cycles -> iREN=1 throughout; pc_en=1 on each of the 5 cycles; instr_cnt=5; dREN=dWEN=0.
2. Load: ihit with ctl_dREN=1 -> pc_en=0, next cycle iREN=0 and dREN=1. Hold 3 cycles with dhit=0 -> dREN remains 1. dhit -> pc_en=1 that cycle; next cycle iREN=1, dREN=0; instr_cnt incremented by exactly 1.
3. Both intents: ihit with ctl_dREN=1 and ctl_dWEN=1 -> dWEN=1, dREN=0. Then dhit -> return to IFETCH.
4. Halt: ihit with ctl_halt=1 and ctl_dWEN=1 -> next cycle halt=1, iREN=0, dWEN=0, instr_cnt+1. Further ihit/dhit pulses -> pc_en stays 0 and halt stays 1 until nRST.
5. Watchdog with TIMEOUT=4: stay in IFETCH with no ihit -> timeout=1 after the 4th waiting cycle; a later ihit -> pc_en=1 and timeout stays 1. With TIMEOUT=0 and 100 idle cycles -> timeout=0.
6. Reset during DACCESS with dWEN=1: assert nRST=0 -> dWEN drops without waiting for CLK. Release -> iREN=1, instr_cnt=0, timeout=0. Also drive CNT_W=4 through 16 retirements -> instr_cnt wraps 15 to 0.
